// File: rtl/minmax_matrix_config_loader.sv
// ============================================================================
// Module   : minmax_matrix_config_loader
// Brief    : Streams lower-triangular min/max comparator configuration words
//            from a valid/ready source into the comparator matrix.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module minmax_matrix_config_loader #(
  parameter int                      ITERATION_VARIABLE_WIDTH = 16,
  parameter int                      DIMENSION                = 3,
  parameter int                      SELECT_WIDTH             = 3,
  parameter logic [SELECT_WIDTH-1:0] MATRIX_SEL_ID            = 3'b100,
  parameter int                      ACK_TIMEOUT              = 15,
  parameter int                      CNT_WIDTH                = 8
) (
  input  logic                                conf_clk,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic [DIMENSION-1:0]                output_selector,
  input  logic [ITERATION_VARIABLE_WIDTH-1:0] src_data,
  input  logic                                src_valid,
  output logic                                src_ready,
  output logic [ITERATION_VARIABLE_WIDTH-1:0] conf_bus,
  output logic [SELECT_WIDTH-1:0]             sel,
  output logic                                mtx_reset,
  input  logic                                conf_ack,
  output logic                                busy,
  output logic                                done,
  output logic                                error,
  output logic [1:0]                          err_code,
  output logic [CNT_WIDTH-1:0]                words_loaded
);

  localparam int c_tmo_w = $clog2(ACK_TIMEOUT + 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(ACK_TIMEOUT - 1);

  localparam logic [2:0] c_idle     = 3'd0;
  localparam logic [2:0] c_clear    = 3'd1;
  localparam logic [2:0] c_load     = 3'd2;
  localparam logic [2:0] c_wait_ack = 3'd3;
  localparam logic [2:0] c_done     = 3'd4;
  localparam logic [2:0] c_error    = 3'd5;

  localparam logic [1:0] c_err_timeout = 2'd1;
  localparam logic [1:0] c_err_early   = 2'd2;
  localparam logic [1:0] c_err_norows  = 2'd3;

  logic [2:0]                          r_state;
  logic [CNT_WIDTH-1:0]                r_count;
  logic [CNT_WIDTH-1:0]                r_total;
  logic [c_tmo_w-1:0]                  r_tmo;
  logic [ITERATION_VARIABLE_WIDTH-1:0] r_conf_bus;
  logic [SELECT_WIDTH-1:0]             r_sel;
  logic                                r_mtx_reset;
  logic [1:0]                          r_err_code;
  logic [CNT_WIDTH-1:0]                w_rows;
  logic                                w_run;
  logic                                w_hs;

  // Active rows are the unbroken run of ones starting at bit 0.
  always_comb begin
    w_rows = '0;
    w_run  = 1'b1;
    for (int i = 0; i < DIMENSION; i++) begin
      if (w_run && output_selector[i]) begin
        w_rows = w_rows + CNT_WIDTH'(1);
      end else begin
        w_run = 1'b0;
      end
    end
  end

  assign src_ready    = (r_state == c_load) && (r_count < r_total);
  assign w_hs         = src_valid && src_ready;
  assign busy         = (r_state == c_clear) || (r_state == c_load) || (r_state == c_wait_ack);
  assign done         = (r_state == c_done);
  assign error        = (r_state == c_error);
  assign err_code     = r_err_code;
  assign words_loaded = r_count;
  assign conf_bus     = r_conf_bus;
  assign sel          = r_sel;
  assign mtx_reset    = r_mtx_reset;

  always_ff @(posedge conf_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= c_idle;
      r_count     <= '0;
      r_total     <= '0;
      r_tmo       <= '0;
      r_conf_bus  <= '0;
      r_sel       <= '0;
      r_mtx_reset <= 1'b0;
      r_err_code  <= 2'd0;
    end else begin
      r_sel       <= '0;
      r_mtx_reset <= 1'b0;
      case (r_state)
        c_idle, c_done, c_error: begin
          if (start) begin
            r_state     <= c_clear;
            r_mtx_reset <= 1'b1;
            r_err_code  <= 2'd0;
            r_count     <= '0;
          end
        end
        c_clear: begin
          r_total <= CNT_WIDTH'(2) * w_rows * (w_rows + CNT_WIDTH'(1));
          r_count <= '0;
          if (w_rows == '0) begin
            r_state    <= c_error;
            r_err_code <= c_err_norows;
          end else begin
            r_state <= c_load;
          end
        end
        c_load: begin
          // An ack before the last word wins over a same-cycle handshake.
          if (conf_ack) begin
            r_state    <= c_error;
            r_err_code <= c_err_early;
          end else if (w_hs) begin
            r_conf_bus <= src_data;
            r_sel      <= MATRIX_SEL_ID;
            r_count    <= r_count + CNT_WIDTH'(1);
            if (r_count + CNT_WIDTH'(1) == r_total) begin
              r_state <= c_wait_ack;
              r_tmo   <= '0;
            end
          end
        end
        c_wait_ack: begin
          if (conf_ack) begin
            r_state <= c_done;
          end else if (r_tmo == c_tmo_last) begin
            r_state    <= c_error;
            r_err_code <= c_err_timeout;
          end else begin
            r_tmo <= r_tmo + c_tmo_w'(1);
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_minmax_matrix_config_loader.sv
// ============================================================================
// Module   : tb_minmax_matrix_config_loader
// Brief    : Randomized self-checking bench with a comparator-matrix model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_minmax_matrix_config_loader;

  localparam int         TMO = 15;
  localparam logic [2:0] ID  = 3'b100;

  logic        conf_clk = 1'b0;
  logic        reset_n, start, src_valid, src_ready, conf_ack;
  logic        mtx_reset, busy, done, error;
  logic [2:0]  output_selector, sel;
  logic [15:0] src_data, conf_bus;
  logic [1:0]  err_code;
  logic [7:0]  words_loaded;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 conf_clk = ~conf_clk;

  minmax_matrix_config_loader dut (
    .conf_clk        (conf_clk),
    .reset_n         (reset_n),
    .start           (start),
    .output_selector (output_selector),
    .src_data        (src_data),
    .src_valid       (src_valid),
    .src_ready       (src_ready),
    .conf_bus        (conf_bus),
    .sel             (sel),
    .mtx_reset       (mtx_reset),
    .conf_ack        (conf_ack),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .err_code        (err_code),
    .words_loaded    (words_loaded)
  );

  // Comparator matrix model: captures words addressed to it, acks after the last.
  logic [15:0] mem [0:23];
  int          mcount;
  logic        mack;
  int          m_expected;
  int          ack_mode;   // 0 normal, 1 ack stuck low
  logic        ack_force;

  always @(posedge conf_clk) begin
    if (mtx_reset) begin
      mcount <= 0;
      mack   <= 1'b0;
    end else if (sel == ID) begin
      if (mcount < 24) mem[mcount] <= conf_bus;
      mcount <= mcount + 1;
      if (mcount + 1 == m_expected) mack <= 1'b1;
    end
  end

  assign conf_ack = (ack_mode == 1) ? 1'b0 : (ack_force | mack);

  // Reference rules: rows = leading run of ones, 4 words per lower-triangular cell.
  function automatic int ref_rows(input logic [2:0] s);
    int r = 0;
    while (r < 3 && s[r]) r++;
    return r;
  endfunction

  function automatic int ref_total(input logic [2:0] s);
    int r = ref_rows(s);
    return 4 * (r * (r + 1) / 2);
  endfunction

  // Observations gathered by the stream driver.
  int          rel, hs_cnt, first_hs, last_hs, end_rel;
  int          sel_viol, bus_viol, ready_seen, rst_seen;
  logic [15:0] sent_q [$];

  task automatic pulse_start(input logic [2:0] os);
    @(negedge conf_clk);
    output_selector = os;
    start = 1'b1;
    @(negedge conf_clk);
    start = 1'b0;
  endtask

  // Drives the source one cycle per negedge, predicting handshakes and sel/bus.
  task automatic drive_stream(input int vmode, input int stop_hs, input int force_after,
                              input int busy_start_rel, input int max_rel);
    logic        prev_hs;
    logic        this_hs;
    logic [15:0] last;
    prev_hs = 1'b0;
    last    = '0;
    sent_q.delete();
    hs_cnt = 0; first_hs = -1; last_hs = -1; end_rel = -1;
    sel_viol = 0; bus_viol = 0; ready_seen = 0; rst_seen = 0;
    src_valid = (vmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    src_data  = 16'($urandom);
    rel = 0;
    while (rel <= max_rel) begin
      if (force_after > 0 && hs_cnt >= force_after && !ack_force) begin
        ack_force = 1'b1;
        #1;
      end
      if ((sel == ID) !== prev_hs) sel_viol++;
      if (prev_hs && conf_bus !== last) bus_viol++;
      if (mtx_reset) rst_seen++;
      if (src_ready) ready_seen++;
      if (done || error) begin
        end_rel = rel;
        break;
      end
      if (stop_hs > 0 && hs_cnt >= stop_hs) break;
      this_hs = src_valid && src_ready && !conf_ack;
      if (this_hs) begin
        sent_q.push_back(src_data);
        hs_cnt++;
        if (first_hs < 0) first_hs = rel + 1;
        last_hs = rel + 1;
      end
      prev_hs = this_hs;
      last    = src_data;
      start   = (rel == busy_start_rel);
      @(negedge conf_clk);
      rel++;
      case (vmode)
        0:       src_valid = 1'b1;
        1:       src_valid = ~src_valid;
        default: src_valid = 1'($urandom_range(0, 1));
      endcase
      src_data = 16'($urandom);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b1; start = 1'b0; src_valid = 1'b0; src_data = '0;
    output_selector = '0; ack_mode = 0; ack_force = 1'b0; m_expected = 0;
    #2 reset_n = 1'b0;
    #10;
    n_assert++;
    if ({conf_bus, sel, mtx_reset, src_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_datapath: got bus=%h sel=%b mrst=%b rdy=%b, want all 0",
               conf_bus, sel, mtx_reset, src_ready);
    end
    n_assert++;
    if ({busy, done, error, err_code, words_loaded} !== '0) begin
      n_fail++;
      $display("FAIL reset_status: got busy=%b done=%b err=%b code=%0d words=%0d, want all 0",
               busy, done, error, err_code, words_loaded);
    end
    @(negedge conf_clk);
    reset_n = 1'b1;
  endtask

  task automatic check_mem(input string name, input int total);
    for (int i = 0; i < total; i++) begin
      n_assert++;
      if (i >= sent_q.size() || mem[i] !== sent_q[i]) begin
        n_fail++;
        $display("FAIL %s word %0d: got %h want %h", name, i, mem[i],
                 (i < sent_q.size()) ? sent_q[i] : 16'hxxxx);
      end
    end
  endtask

  task automatic test_full_load();
    m_expected = ref_total(3'b111);
    pulse_start(3'b111);
    n_assert++;
    if (mtx_reset !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL full_clear: got mrst=%b busy=%b want 1 1", mtx_reset, busy);
    end
    drive_stream(0, 0, 0, -1, 200);
    n_assert++;
    if (rst_seen != 1) begin
      n_fail++; $display("FAIL full_mrst_cycles: got %0d want 1", rst_seen);
    end
    n_assert++;
    if (first_hs != 2 || last_hs != 25 || hs_cnt != 24) begin
      n_fail++;
      $display("FAIL full_handshakes: got first=%0d last=%0d n=%0d want 2 25 24",
               first_hs, last_hs, hs_cnt);
    end
    n_assert++;
    if (sel_viol != 0 || bus_viol != 0) begin
      n_fail++; $display("FAIL full_sel_bus: got %0d/%0d bad cycles want 0", sel_viol, bus_viol);
    end
    n_assert++;
    if (end_rel != 27 || done !== 1'b1) begin
      n_fail++; $display("FAIL full_done_edge: got edge %0d done=%b want 27 1", end_rel, done);
    end
    n_assert++;
    if (int'(words_loaded) != 24 || err_code !== 2'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_status: got words=%0d code=%0d busy=%b want 24 0 0",
               words_loaded, err_code, busy);
    end
    check_mem("full_matrix", 24);
  endtask

  task automatic test_toggle_valid();
    m_expected = ref_total(3'b011);
    pulse_start(3'b011);
    drive_stream(1, 0, 0, -1, 200);
    n_assert++;
    if (hs_cnt != m_expected || sel_viol != 0 || bus_viol != 0) begin
      n_fail++;
      $display("FAIL toggle_words: got n=%0d selbad=%0d busbad=%0d want %0d 0 0",
               hs_cnt, sel_viol, bus_viol, m_expected);
    end
    n_assert++;
    if (done !== 1'b1 || int'(words_loaded) != 12) begin
      n_fail++; $display("FAIL toggle_done: got done=%b words=%0d want 1 12", done, words_loaded);
    end
    check_mem("toggle_matrix", 12);
  endtask

  task automatic test_no_rows();
    pulse_start(3'b000);
    drive_stream(0, 0, 0, -1, 50);
    n_assert++;
    if (error !== 1'b1 || err_code !== 2'd3 || end_rel != 1) begin
      n_fail++;
      $display("FAIL norows_error: got err=%b code=%0d edge=%0d want 1 3 1", error, err_code, end_rel);
    end
    n_assert++;
    if (ready_seen != 0 || hs_cnt != 0 || sel_viol != 0) begin
      n_fail++;
      $display("FAIL norows_quiet: got ready=%0d hs=%0d selbad=%0d want 0 0 0",
               ready_seen, hs_cnt, sel_viol);
    end
  endtask

  task automatic test_ack_timeout();
    ack_mode = 1;
    m_expected = ref_total(3'b101);
    pulse_start(3'b101);
    drive_stream(0, 0, 0, -1, 200);
    n_assert++;
    if (error !== 1'b1 || err_code !== 2'd1 || int'(words_loaded) != 4) begin
      n_fail++;
      $display("FAIL timeout_status: got err=%b code=%0d words=%0d want 1 1 4",
               error, err_code, words_loaded);
    end
    n_assert++;
    if (end_rel - last_hs != TMO) begin
      n_fail++; $display("FAIL timeout_cycles: got %0d want %0d", end_rel - last_hs, TMO);
    end
    ack_mode = 0;
  endtask

  task automatic test_early_ack();
    m_expected = ref_total(3'b111);
    pulse_start(3'b111);
    drive_stream(0, 0, 2, -1, 200);
    n_assert++;
    if (error !== 1'b1 || err_code !== 2'd2 || int'(words_loaded) != 2 || hs_cnt != 2) begin
      n_fail++;
      $display("FAIL early_status: got err=%b code=%0d words=%0d hs=%0d want 1 2 2 2",
               error, err_code, words_loaded, hs_cnt);
    end
    n_assert++;
    if (src_ready !== 1'b0 || end_rel != 4 || sel_viol != 0) begin
      n_fail++;
      $display("FAIL early_stop: got rdy=%b edge=%0d selbad=%0d want 0 4 0", src_ready, end_rel, sel_viol);
    end
    ack_force = 1'b0;
  endtask

  task automatic test_reset_midload();
    m_expected = ref_total(3'b111);
    pulse_start(3'b111);
    drive_stream(0, 7, 0, -1, 200);
    reset_n = 1'b0;
    #1;
    n_assert++;
    if ({conf_bus, sel, mtx_reset, src_ready, busy, done, error, err_code, words_loaded} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got bus=%h sel=%b rdy=%b busy=%b words=%0d want all 0",
               conf_bus, sel, src_ready, busy, words_loaded);
    end
    #2 reset_n = 1'b1;
    pulse_start(3'b111);
    drive_stream(0, 0, 0, 10, 200);
    n_assert++;
    if (done !== 1'b1 || int'(words_loaded) != 24 || end_rel != 27 || hs_cnt != 24) begin
      n_fail++;
      $display("FAIL rerun_done: got done=%b words=%0d edge=%0d hs=%0d want 1 24 27 24",
               done, words_loaded, end_rel, hs_cnt);
    end
    check_mem("rerun_matrix", 24);
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      logic [2:0] os;
      int         total;
      os = 3'($urandom);
      if (it == 0) os = 3'b111;
      total = ref_total(os);
      m_expected = total;
      pulse_start(os);
      drive_stream(2, 0, 0, -1, 600);
      n_assert++;
      if (total == 0) begin
        if (error !== 1'b1 || err_code !== 2'd3) begin
          n_fail++;
          $display("FAIL random_norows os=%b: got err=%b code=%0d want 1 3", os, error, err_code);
        end
      end else if (done !== 1'b1 || int'(words_loaded) != total || hs_cnt != total ||
                   sel_viol != 0 || bus_viol != 0) begin
        n_fail++;
        $display("FAIL random_load os=%b: got done=%b words=%0d hs=%0d selbad=%0d want 1 %0d %0d 0",
                 os, done, words_loaded, hs_cnt, sel_viol, total, total);
      end
      check_mem("random_matrix", total);
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_toggle_valid();
    test_no_rows();
    test_ack_timeout();
    test_early_ack();
    test_reset_midload();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
